// File: rtl/q_pkg.sv
// Shared types and helpers for the Q inverse (operand-a recovery) block.
// Default widths here match a DATA_WIDTH of 16.
package q_pkg;

    localparam int Q_DATA_W = 16;
    localparam int Q_QW     = 2 * Q_DATA_W + 3;
    localparam int Q_NUM_W  = 2 * Q_DATA_W + 5;
    localparam int Q_KW     = Q_DATA_W + 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        DIV    = 3'd2,
        CHECK  = 3'd3,
        RESULT = 3'd4
    } q_state_e;

    // Clamp a signed value into the signed range of a w-bit word.
    function automatic logic [63:0] saturate(input logic signed [63:0] x, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi) begin
            return hi;
        end
        if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/q_udiv_serial.sv
// Unsigned restoring divider, one quotient bit per cycle after a start pulse.
// done is high during the cycle whose clock edge performs the final step.
module q_udiv_serial
    import q_pkg::*;
#(
    parameter int N  = Q_NUM_W,
    parameter int DW = Q_KW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [N-1:0]  dividend,
    input  logic [DW-1:0] divisor,
    output logic          done,
    output logic [N-1:0]  quotient,
    output logic [DW-1:0] remainder
);

    localparam int CW = $clog2(N);

    logic [N-1:0]  quot_q, quot_d;
    logic [DW-1:0] rem_q, rem_d;
    logic [DW-1:0] dvs_q, dvs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          run_q, run_d;

    logic [DW:0]   rem_sh;
    logic [DW-1:0] rem_sub;
    logic          fits;

    always_comb begin
        rem_sh  = {rem_q, quot_q[N-1]};
        fits    = (rem_sh >= {1'b0, dvs_q});
        // When fits is set the true difference is below the divisor, so DW bits hold it.
        rem_sub = rem_sh[DW-1:0] - dvs_q;

        quot_d = quot_q;
        rem_d  = rem_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        run_d  = run_q;

        if (start) begin
            quot_d = dividend;
            rem_d  = '0;
            dvs_d  = divisor;
            cnt_d  = CW'(N - 1);
            run_d  = 1'b1;
        end else if (run_q) begin
            rem_d  = fits ? rem_sub : rem_sh[DW-1:0];
            quot_d = {quot_q[N-2:0], fits};
            if (cnt_q == '0) begin
                run_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            quot_q <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
        end else begin
            quot_q <= quot_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
        end
    end

    assign done      = run_q && (cnt_q == '0);
    assign quotient  = quot_q;
    assign remainder = rem_q;

endmodule

// File: rtl/q_inverse.sv
// Recovers operand a from Q = ((a - b)*(1 + 3c) - 4d) >>> 1 by dividing 2Q + 4d (or +1) by 1 + 3c.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high.
module q_inverse
    import q_pkg::*;
#(
    parameter int DATA_WIDTH = Q_DATA_W
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           q_valid,
    output logic                           q_ready,
    input  logic signed [2*DATA_WIDTH+2:0] Q,
    input  logic signed [DATA_WIDTH-1:0]   b,
    input  logic signed [DATA_WIDTH-1:0]   c,
    input  logic signed [DATA_WIDTH-1:0]   d,
    output logic                           a_valid,
    input  logic                           a_ready,
    output logic signed [DATA_WIDTH-1:0]   a,
    output logic                           exact,
    output logic                           range_err,
    output logic                           busy,
    output q_state_e                       dbg_state
);

    localparam int W  = DATA_WIDTH;
    localparam int QW = 2 * W + 3;
    localparam int N  = 2 * W + 5;
    localparam int KW = W + 3;

    q_state_e      state_q, state_d;
    logic [QW-1:0] qin_q, qin_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  c_q, c_d;
    logic [W-1:0]  d_q, d_d;
    logic          attempt_q, attempt_d;
    logic          neg_q, neg_d;
    logic [N:0]    quot0_q, quot0_d;
    logic [W-1:0]  a_q, a_d;
    logic          exact_q, exact_d;
    logic          range_err_q, range_err_d;
    logic          a_valid_q, a_valid_d;
    logic          q_ready_q, q_ready_d;
    logic          busy_q, busy_d;

    logic          div_start;
    logic          div_done;
    logic [N-1:0]  div_quot;
    logic [KW-1:0] div_rem;

    logic [N-1:0]  m_cur;
    logic [N-1:0]  m_mag;
    logic [KW-1:0] k_ext;
    logic [KW-1:0] k_val;
    logic [KW-1:0] k_mag;
    logic [N:0]    quot_mag;
    logic [N:0]    quot_signed;
    logic [N:0]    quot_sel;
    logic [N+1:0]  sum;
    logic [63:0]   sum64;
    logic [63:0]   sat_val;

    // Candidate dividend 2Q + 4d (+1 on the second attempt) and divisor 1 + 3c.
    always_comb begin
        m_cur = ({{(N-QW){qin_q[QW-1]}}, qin_q} << 1)
              + ({{(N-W){d_q[W-1]}}, d_q} << 2)
              + {{(N-1){1'b0}}, attempt_q};
        m_mag = m_cur[N-1] ? -m_cur : m_cur;

        k_ext = {{(KW-W){c_q[W-1]}}, c_q};
        k_val = (k_ext << 1) + k_ext + {{(KW-1){1'b0}}, 1'b1};
        k_mag = k_val[KW-1] ? -k_val : k_val;
    end

    // Quotient sign is applied after the unsigned divide; truncation is toward zero.
    always_comb begin
        quot_mag    = {1'b0, div_quot};
        quot_signed = neg_q ? -quot_mag : quot_mag;
        quot_sel    = (div_rem == '0) ? quot_signed : quot0_q;
        sum         = {{(N+2-W){b_q[W-1]}}, b_q} + {quot_sel[N], quot_sel};
        sum64       = {{(64-N-2){sum[N+1]}}, sum};
        sat_val     = saturate(sum64, W);
    end

    always_comb begin
        state_d     = state_q;
        qin_d       = qin_q;
        b_d         = b_q;
        c_d         = c_q;
        d_d         = d_q;
        attempt_d   = attempt_q;
        neg_d       = neg_q;
        quot0_d     = quot0_q;
        a_d         = a_q;
        exact_d     = exact_q;
        range_err_d = range_err_q;
        a_valid_d   = a_valid_q;
        q_ready_d   = q_ready_q;
        busy_d      = busy_q;
        div_start   = 1'b0;

        case (state_q)
            IDLE: begin
                if (q_valid) begin
                    qin_d     = Q;
                    b_d       = b;
                    c_d       = c;
                    d_d       = d;
                    attempt_d = 1'b0;
                    q_ready_d = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                div_start = 1'b1;
                neg_d     = m_cur[N-1] ^ k_val[KW-1];
                state_d   = DIV;
            end
            DIV: begin
                if (div_done) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (div_rem == '0 || attempt_q) begin
                    // An inexact second attempt falls back to the first quotient via quot_sel.
                    exact_d     = (div_rem == '0);
                    a_d         = sat_val[W-1:0];
                    range_err_d = (sat_val != sum64);
                    a_valid_d   = 1'b1;
                    state_d     = RESULT;
                end else begin
                    quot0_d   = quot_signed;
                    attempt_d = 1'b1;
                    state_d   = SETUP;
                end
            end
            RESULT: begin
                if (a_ready) begin
                    a_valid_d = 1'b0;
                    q_ready_d = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                a_valid_d = 1'b0;
                q_ready_d = 1'b1;
                busy_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            qin_q       <= '0;
            b_q         <= '0;
            c_q         <= '0;
            d_q         <= '0;
            attempt_q   <= 1'b0;
            neg_q       <= 1'b0;
            quot0_q     <= '0;
            a_q         <= '0;
            exact_q     <= 1'b0;
            range_err_q <= 1'b0;
            a_valid_q   <= 1'b0;
            q_ready_q   <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            qin_q       <= qin_d;
            b_q         <= b_d;
            c_q         <= c_d;
            d_q         <= d_d;
            attempt_q   <= attempt_d;
            neg_q       <= neg_d;
            quot0_q     <= quot0_d;
            a_q         <= a_d;
            exact_q     <= exact_d;
            range_err_q <= range_err_d;
            a_valid_q   <= a_valid_d;
            q_ready_q   <= q_ready_d;
            busy_q      <= busy_d;
        end
    end

    q_udiv_serial #(
        .N  (N),
        .DW (KW)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .dividend  (m_mag),
        .divisor   (k_mag),
        .done      (div_done),
        .quotient  (div_quot),
        .remainder (div_rem)
    );

    assign q_ready   = q_ready_q;
    assign a_valid   = a_valid_q;
    assign a         = a_q;
    assign exact     = exact_q;
    assign range_err = range_err_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_q_inverse.sv
// Bench for q_inverse: directed vector table, hand-written corner sequences,
// and random operations checked against an arithmetic model of the inverse.
module tb_q_inverse;
    import q_pkg::*;

    localparam int W  = Q_DATA_W;
    localparam int QW = Q_QW;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 q_valid = 1'b0;
    logic                 q_ready;
    logic signed [QW-1:0] q_in = '0;
    logic signed [W-1:0]  b_in = '0;
    logic signed [W-1:0]  c_in = '0;
    logic signed [W-1:0]  d_in = '0;
    logic                 a_valid;
    logic                 a_ready = 1'b0;
    logic signed [W-1:0]  a;
    logic                 exact;
    logic                 range_err;
    logic                 busy;
    q_state_e             dbg_state;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    typedef struct {
        longint q;
        longint b;
        longint c;
        longint d;
        longint exp_a;
        bit     exp_exact;
        bit     exp_range;
        int     exp_lat;
    } vec_t;

    vec_t vecs[7];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    q_inverse #(.DATA_WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .q_valid   (q_valid),
        .q_ready   (q_ready),
        .Q         (q_in),
        .b         (b_in),
        .c         (c_in),
        .d         (d_in),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a         (a),
        .exact     (exact),
        .range_err (range_err),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Reference model: inverse computed directly from the arithmetic definition.
    task automatic model(input longint qv, input longint bv, input longint cv, input longint dv,
                         output longint av, output bit ex, output bit rg, output int lat);
        longint k, m0, m1, q0, q1, r0, r1, quot, s, hi, lo;
        k  = 1 + 3 * cv;
        m0 = 2 * qv + 4 * dv;
        m1 = m0 + 1;
        q0 = m0 / k;
        r0 = m0 % k;
        q1 = m1 / k;
        r1 = m1 % k;
        if (r0 == 0) begin
            quot = q0; ex = 1'b1; lat = 39;
        end else if (r1 == 0) begin
            quot = q1; ex = 1'b1; lat = 78;
        end else begin
            quot = q0; ex = 1'b0; lat = 78;
        end
        s  = bv + quot;
        hi = (longint'(1) <<< (W - 1)) - 1;
        lo = -(longint'(1) <<< (W - 1));
        rg = 1'b0;
        av = s;
        if (s > hi) begin av = hi; rg = 1'b1; end
        if (s < lo) begin av = lo; rg = 1'b1; end
    endtask

    // ---------------- driver ----------------
    // Present one operation, measure latency, check the result, hold it for
    // 'hold' cycles with a_ready low, then complete the output handshake.
    task automatic do_op(input longint qv, input longint bv, input longint cv, input longint dv,
                         input longint ea, input bit ee, input bit er, input int elat,
                         input int hold, input string tag);
        int n;
        int lat;
        logic [W-1:0] ev;
        logic [W-1:0] a_u;
        exp_q.push_back(ea[W-1:0]);
        n = 0;
        while (!q_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        check({tag, " q_ready_before_accept"}, 64'(q_ready), 64'd1);
        q_in    = qv[QW-1:0];
        b_in    = bv[W-1:0];
        c_in    = cv[W-1:0];
        d_in    = dv[W-1:0];
        q_valid = 1'b1;
        @(posedge clk); #1;
        q_valid = 1'b0;
        check({tag, " busy_after_accept"}, 64'(busy), 64'd1);
        lat = 0;
        while (!a_valid && lat < 300) begin
            @(posedge clk); #1; lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(elat));
        ev  = exp_q.pop_front();
        a_u = a;
        check({tag, " a"}, 64'(a_u), 64'(ev));
        check({tag, " exact"}, 64'(exact), 64'(ee));
        check({tag, " range_err"}, 64'(range_err), 64'(er));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            a_u = a;
            check({tag, " hold_a"}, 64'(a_u), 64'(ev));
            check({tag, " hold_a_valid"}, 64'(a_valid), 64'd1);
            check({tag, " hold_exact"}, 64'(exact), 64'(ee));
            check({tag, " hold_q_ready"}, 64'(q_ready), 64'd0);
        end
        a_ready = 1'b1;
        @(posedge clk); #1;
        a_ready = 1'b0;
        check({tag, " a_valid_after_handshake"}, 64'(a_valid), 64'd0);
        check({tag, " q_ready_after_handshake"}, 64'(q_ready), 64'd1);
    endtask

    task automatic check_reset_values(input string tag);
        logic [W-1:0] a_u;
        a_u = a;
        check({tag, " q_ready"}, 64'(q_ready), 64'd1);
        check({tag, " a_valid"}, 64'(a_valid), 64'd0);
        check({tag, " a"}, 64'(a_u), 64'd0);
        check({tag, " exact"}, 64'(exact), 64'd0);
        check({tag, " range_err"}, 64'(range_err), 64'd0);
        check({tag, " busy"}, 64'(busy), 64'd0);
        check({tag, " state"}, 64'(dbg_state), 64'(IDLE));
    endtask

    // ---------------- test ----------------
    initial begin
        longint qv, bv, cv, dv, av, ea, t;
        bit ee, er;
        int elat, seen;

        vecs[0] = '{4,       1,  1, 2,  5,      1'b1, 1'b0, 39};
        vecs[1] = '{14,      3,  2, 5,  10,     1'b1, 1'b0, 78};
        vecs[2] = '{34,      2, -3, 1, -7,      1'b1, 1'b0, 39};
        vecs[3] = '{1,       0,  1, 0,  0,      1'b0, 1'b0, 78};
        vecs[4] = '{100000,  0,  0, 0,  32767,  1'b1, 1'b1, 39};
        vecs[5] = '{3,       0,  0, 0,  6,      1'b1, 1'b0, 39};
        vecs[6] = '{-100000, 0,  0, 0, -32768,  1'b1, 1'b1, 39};

        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b1;
        @(posedge clk); #1;

        // Directed table; the first entry also exercises a 10-cycle output stall.
        for (int i = 0; i < 7; i++) begin
            do_op(vecs[i].q, vecs[i].b, vecs[i].c, vecs[i].d,
                  vecs[i].exp_a, vecs[i].exp_exact, vecs[i].exp_range, vecs[i].exp_lat,
                  (i == 0) ? 10 : 1, $sformatf("vec%0d", i));
        end

        // Reset while the divider is running: no result may appear afterwards.
        q_in = 35'sd14; b_in = 16'sd3; c_in = 16'sd2; d_in = 16'sd5;
        q_valid = 1'b1;
        @(posedge clk); #1;
        q_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("mid_reset state_before", 64'(dbg_state), 64'(DIV));
        rst = 1'b0;
        #2;
        check_reset_values("mid_reset");
        @(posedge clk); #1;
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (a_valid) seen++;
        end
        check("mid_reset no_a_valid", 64'(seen), 64'd0);
        check("mid_reset q_ready_idle", 64'(q_ready), 64'd1);

        // Random operations against the model.
        for (int i = 0; i < 30; i++) begin
            bv = longint'($urandom_range(0, 65535)) - 32768;
            dv = longint'($urandom_range(0, 65535)) - 32768;
            case ($urandom_range(0, 2))
                0: begin
                    av = longint'($urandom_range(0, 65535)) - 32768;
                    cv = longint'($urandom_range(0, 65535)) - 32768;
                    qv = ((av - bv) * (1 + 3 * cv) - 4 * dv) >>> 1;
                end
                1: begin
                    av = longint'($urandom_range(0, 65535)) - 32768;
                    cv = longint'($urandom_range(0, 4)) - 2;
                    dv = longint'($urandom_range(0, 200)) - 100;
                    qv = ((av - bv) * (1 + 3 * cv) - 4 * dv) >>> 1;
                end
                default: begin
                    cv = longint'($urandom_range(0, 65535)) - 32768;
                    t  = longint'({$urandom(), $urandom()});
                    qv = (t <<< (64 - QW)) >>> (64 - QW);
                end
            endcase
            model(qv, bv, cv, dv, ea, ee, er, elat);
            do_op(qv, bv, cv, dv, ea, ee, er, elat, $urandom_range(0, 3), $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/q_inverse.md
Name: q_inverse

Overview:
- Inverse of the team's Q datapath, which computes Q = ((a - b)*(1 + 3c) - 4d) >>> 1.
- Given a result Q and the side operands b, c, d, this block recovers operand a using a serial restoring divider (one quotient bit per cycle).
- Sits on the verification/readback path: consumes Q words and produces reconstructed a, with exactness and range flags.
- Valid/ready handshake on both sides.

Parameters:
- DATA_WIDTH, 16, width W of a, b, c, d; Q width is 2W+3.
- NUM_W, 2*DATA_WIDTH+5, dividend magnitude width and divider iteration count (derived; not overridden).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- q_valid  in  1  Q/b/c/d presented
- q_ready  out  1  block can accept
- Q  in  2W+3 signed  forward result
- b, c, d  in  W signed each  side operands
- a_valid  out  1  result presented
- a_ready  in  1  downstream accepts result
- a  out  W signed  reconstructed operand
- exact  out  1  division was exact
- range_err  out  1  a saturated
- busy  out  1  state != IDLE

Behaviour:
- Reset rst, asynchronous, active-low; clock clk.
- Reset values: q_ready=1, a_valid=0, a=0, exact=0, range_err=0, busy=0, state=IDLE.
- Reset mid-operation aborts and returns to IDLE; no result is emitted.
- Math:
  - k = 1 + 3c, sign-extended to W+3 bits; k is never 0.
  - Candidate 0: M0 = 2Q + 4d, NUM_W signed. Candidate 1: M1 = M0 + 1. This covers the floor of >>>1.
  - Division is sign-magnitude: |M| / |k|. Quotient sign = sign(M) XOR sign(k), truncated toward zero. Exact iff remainder == 0.
- States:
  - IDLE: q_ready=1. On q_valid: capture Q, b, c, d, set attempt=0, go to SETUP.
  - SETUP: form M (M0 or M1 per attempt), |M|, |k|, and the quotient sign. Load counter = NUM_W-1. Go to DIV.
  - DIV: one restoring step per cycle. After NUM_W steps, go to CHECK.
  - CHECK:
    - rem==0: exact=1, go to RESULT.
    - rem!=0 and attempt=0: store quotient0, set attempt=1, go to SETUP.
    - rem!=0 and attempt=1: exact=0, use quotient0, go to RESULT.
  - RESULT: a = sat_W(b + quotient), range_err=1 if saturation occurred. a_valid=1. Outputs stay stable until a_ready. On handshake go to IDLE; a_valid drops on the next edge.
- Latency, counted from the accept edge to a_valid high:
  - Candidate 0 exact: NUM_W+2 = 39 cycles.
  - Candidate 1 needed: 2*NUM_W+4 = 78 cycles.
- q_ready is high only in IDLE. There is no overlap between operations; accept-in-RESULT is not supported.
- |k|=1: both candidates are exact and the even candidate (M0) is chosen by rule.
- Saturation bounds: -2^(W-1) and 2^(W-1)-1.

Decomposition:
- Package q_pkg holds:
  - state enum (IDLE, SETUP, DIV, CHECK, RESULT)
  - localparams for Q width (2W+3), NUM_W, and k width (W+3)
  - a saturate function
- Sub-module q_udiv_serial: unsigned restoring divider with start/done and quotient/remainder. It is instantiated once and reused for both candidates.

Test Plan:
- Q=4, b=1, c=1, d=2 (k=4, M0=16) -> a=5, exact=1, range_err=0, a_valid 39 cycles after accept.
- Q=14, b=3, c=2, d=5 (k=7, M0=48 inexact, M1=49) -> a=10, exact=1, a_valid 78 cycles after accept.
- Q=34, b=2, c=-3, d=1 (k=-8, M0=72, quotient -9) -> a=-7, exact=1.
- Q=1, b=0, c=1, d=0 (M0=2, M1=3, both inexact by 4) -> a=0, exact=0, latency 78.
- Q=100000, b=0, c=0, d=0 -> a=32767, range_err=1, exact=1.
- Hold a_ready=0 for 10 cycles after a_valid: a and flags stable, q_ready=0. Then a_ready=1, then q_valid the next cycle: accepted. Also deassert rst mid-DIV: outputs return to reset values and no a_valid is produced.
